// File: rtl/dac_scan_sequencer.sv
// Walks the enabled DAC channels in ascending order, issuing one 24-bit write
// word per channel from a local code table, then an update-all word and an idle gap.
module dac_scan_sequencer #(
    parameter int         NUM_CH     = 8,
    parameter int         CH_W       = 3,
    parameter int         DATA_W     = 16,
    parameter logic [3:0] CMD_WRITE  = 4'h0,
    parameter logic [3:0] CMD_UPDATE = 4'h1,
    parameter int         GAP_CYCLES = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              tbl_we,
    input  logic [CH_W-1:0]   tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [23:0]       word_data,
    output logic              busy,
    output logic              scan_done
);

    localparam int              GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_UPD_LOAD,
        ST_UPD,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                word_valid_q, word_valid_d;
    logic [23:0]         word_data_q, word_data_d;
    logic                scan_done_q, scan_done_d;
    logic [DATA_W-1:0]   tbl_q [NUM_CH];
    logic [DATA_W-1:0]   tbl_d [NUM_CH];

    logic                last_ch;
    logic                start_ok;

    assign last_ch  = (ch_idx_q == LAST_CH);
    assign start_ok = en && (ch_mask != '0);

    // The FSM reads tbl_q, so a write in the same cycle is seen only from the next cycle on.
    always_comb begin
        tbl_d = tbl_q;
        if (tbl_we) begin
            tbl_d[tbl_addr] = tbl_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        mask_d       = mask_q;
        gap_d        = gap_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        scan_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    mask_d   = ch_mask;
                    ch_idx_d = '0;
                    state_d  = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (mask_q[ch_idx_q]) begin
                    word_data_d  = {CMD_WRITE, 4'(ch_idx_q), tbl_q[ch_idx_q]};
                    word_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (last_ch) begin
                    state_d = ST_UPD_LOAD;
                end else begin
                    ch_idx_d = ch_idx_q + 1'b1;
                end
            end

            ST_ISSUE: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    if (last_ch) begin
                        state_d = ST_UPD_LOAD;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                        state_d  = ST_SCAN;
                    end
                end
            end

            ST_UPD_LOAD: begin
                word_data_d  = {CMD_UPDATE, 4'hF, {DATA_W{1'b0}}};
                word_valid_d = 1'b1;
                state_d      = ST_UPD;
            end

            ST_UPD: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    scan_done_d  = 1'b1;
                    if (en) begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    if (start_ok) begin
                        mask_d   = ch_mask;
                        ch_idx_d = '0;
                        state_d  = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_idx_q     <= '0;
            mask_q       <= '0;
            gap_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            scan_done_q  <= 1'b0;
            tbl_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            mask_q       <= mask_d;
            gap_q        <= gap_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            scan_done_q  <= scan_done_d;
            tbl_q        <= tbl_d;
        end
    end

    // Handshake outputs come straight from flops, so word_valid never depends on word_ready.
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign scan_done  = scan_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Directed bench for dac_scan_sequencer: scenario tasks with inline checks against
// an expected word queue built from hand-computed values.
module tb_dac_scan_sequencer;

    localparam int GAP = 13;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  ch_mask;
    logic        tbl_we;
    logic [2:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        word_valid;
    logic        word_ready;
    logic [23:0] word_data;
    logic        busy;
    logic        scan_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          done_q[$];
    int          vrise_q[$];
    logic        prev_v = 1'b0;

    dac_scan_sequencer #(
        .NUM_CH(8), .CH_W(3), .DATA_W(16),
        .CMD_WRITE(4'h0), .CMD_UPDATE(4'h1), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .busy(busy), .scan_done(scan_done)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: accepted words, scan_done pulses, valid rises
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid && word_ready) got_q.push_back(word_data);
            if (scan_done) done_q.push_back(cyc);
            if (word_valid && !prev_v) vrise_q.push_back(cyc);
        end
        prev_v = word_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_q.delete();
        vrise_q.delete();
        exp_q.delete();
    endtask

    task automatic write_tbl(input logic [2:0] a, input logic [15:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = d;
        step();
        tbl_we   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_q.size() < target && k < budget) begin
            step();
            k++;
        end
        if (done_q.size() < target) begin
            n_checks++;
            $display("FAIL wait_done: scan_done count %0d, required %0d", done_q.size(), target);
        end
    endtask

    function automatic logic [23:0] wr_word(input int ch, input logic [15:0] d);
        return {4'h0, 4'(ch), d};
    endfunction

    function automatic logic [15:0] std_val(input int ch);
        return 16'(32'h1000 * ch + 32'h00AB);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; ch_mask = 8'hFF; word_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (word_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", word_valid); else n_pass++;
        n_checks++; if (word_data !== 24'h0) $display("FAIL rst_data: got %h want 000000", word_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (scan_done !== 1'b0) $display("FAIL rst_done: got %b want 0", scan_done); else n_pass++;
        clear_mon();
        rst_n = 1'b1;
        step();
        en = 1'b0;
        wait_done(1, 100);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, 16'h0000));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rst_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL rst_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        step();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_full_scan();
        int c;
        int k = 0;
        for (int i = 0; i < 8; i++) write_tbl(3'(i), std_val(i));
        clear_mon();
        ch_mask = 8'hFF;
        c = cyc;
        en = 1'b1;
        while (vrise_q.size() < 10 && k < 100) begin
            step();
            k++;
        end
        en = 1'b0;
        wait_done(2, 80);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, std_val(i)));
            exp_q.push_back(24'h1F0000);
        end
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL full_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (vrise_q.size() < 10 || done_q.size() < 1) begin
            $display("FAIL full_timing: valid rises %0d want 10+, done pulses %0d want 1+", vrise_q.size(), done_q.size());
        end else begin
            n_pass++;
            n_checks++; if (vrise_q[0] !== c + 2) $display("FAIL full_first_lat: got %0d want %0d", vrise_q[0], c + 2); else n_pass++;
            n_checks++; if (vrise_q[1] !== c + 4) $display("FAIL full_b2b: got %0d want %0d", vrise_q[1], c + 4); else n_pass++;
            n_checks++; if (done_q[0] !== c + 19) $display("FAIL full_done_cyc: got %0d want %0d", done_q[0], c + 19); else n_pass++;
            n_checks++; if (vrise_q[9] !== done_q[0] + GAP + 2) $display("FAIL full_gap: got %0d want %0d", vrise_q[9], done_q[0] + GAP + 2); else n_pass++;
        end
        n_checks++; if (done_q.size() !== 2) $display("FAIL full_done_count: got %0d want 2", done_q.size()); else n_pass++;
    endtask

    task automatic test_sparse();
        int c;
        clear_mon();
        ch_mask = 8'h05;
        c = cyc;
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done(1, 60);
        exp_q.push_back(24'h0000AB);
        exp_q.push_back(24'h0220AB);
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL sparse_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL sparse_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (vrise_q.size() !== 3 || done_q.size() !== 1) begin
            $display("FAIL sparse_timing: valid rises %0d want 3, done pulses %0d want 1", vrise_q.size(), done_q.size());
        end else begin
            n_pass++;
            n_checks++; if (vrise_q[0] !== c + 2) $display("FAIL sparse_t0: got %0d want %0d", vrise_q[0], c + 2); else n_pass++;
            n_checks++; if (vrise_q[1] !== c + 5) $display("FAIL sparse_t2: got %0d want %0d", vrise_q[1], c + 5); else n_pass++;
            n_checks++; if (vrise_q[2] !== c + 12) $display("FAIL sparse_tupd: got %0d want %0d", vrise_q[2], c + 12); else n_pass++;
            n_checks++; if (done_q[0] !== c + 13) $display("FAIL sparse_done: got %0d want %0d", done_q[0], c + 13); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic        pv, pr;
        logic [23:0] pd;
        int k = 0;
        clear_mon();
        ch_mask = 8'hFF;
        en = 1'b1;
        step();
        en = 1'b0;
        pv = word_valid; pd = word_data;
        word_ready = 1'($urandom_range(0, 1));
        pr = word_ready;
        while (done_q.size() == 0 && k < 300) begin
            step();
            k++;
            if (pv && !pr) begin
                n_checks++;
                if (word_valid !== 1'b1 || word_data !== pd)
                    $display("FAIL bp_stall: got valid=%b data=%h want valid=1 data=%h", word_valid, word_data, pd);
                else n_pass++;
            end
            pv = word_valid; pd = word_data;
            word_ready = 1'($urandom_range(0, 1));
            pr = word_ready;
        end
        if (done_q.size() == 0) begin
            n_checks++;
            $display("FAIL bp_timeout: scan_done count 0 want 1");
        end
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, std_val(i)));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL bp_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        step();
    endtask

    task automatic test_en_drop();
        int k = 0;
        int nr;
        clear_mon();
        ch_mask = 8'hFF;
        en = 1'b1;
        while (en && k < 40) begin
            step();
            k++;
            if (word_valid && word_data[23:16] == 8'h03) en = 1'b0;
        end
        en = 1'b0;
        wait_done(1, 60);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, std_val(i)));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL endrop_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL endrop_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL endrop_busy: got %b want 0", busy); else n_pass++;
        nr = vrise_q.size();
        repeat (20) step();
        n_checks++; if (vrise_q.size() !== nr) $display("FAIL endrop_quiet: got %0d valid rises want %0d", vrise_q.size(), nr); else n_pass++;
        n_checks++; if (done_q.size() !== 1) $display("FAIL endrop_done: got %0d want 1", done_q.size()); else n_pass++;
    endtask

    task automatic test_table_write();
        int  k = 0;
        int  j = 0;
        logic wrote = 1'b0;
        // Write to ch5 while ch2 is being issued
        clear_mon();
        ch_mask = 8'hFF;
        en = 1'b1;
        step();
        en = 1'b0;
        while (!wrote && k < 20) begin
            if (word_valid && word_data[23:16] == 8'h02) begin
                write_tbl(3'd5, 16'hBEEF);
                wrote = 1'b1;
            end else begin
                step();
            end
            k++;
        end
        n_checks++; if (wrote !== 1'b1) $display("FAIL tw_ch2_seen: got %b want 1", wrote); else n_pass++;
        wait_done(1, 60);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, (i == 5) ? 16'hBEEF : std_val(i)));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL tw_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL tw_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
        // Write to ch5 on the very edge where SCAN loads ch5
        clear_mon();
        en = 1'b1;
        repeat (11) step();
        write_tbl(3'd5, 16'h1234);
        n_checks++; if (word_valid !== 1'b1) $display("FAIL tw_same_valid: got %b want 1", word_valid); else n_pass++;
        n_checks++; if (word_data !== 24'h05BEEF) $display("FAIL tw_same_old: got %h want 05BEEF", word_data); else n_pass++;
        wait_done(1, 60);
        while (vrise_q.size() < 10 && j < 60) begin
            step();
            j++;
        end
        en = 1'b0;
        wait_done(2, 60);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, (i == 5) ? 16'hBEEF : std_val(i)));
        exp_q.push_back(24'h1F0000);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, (i == 5) ? 16'h1234 : std_val(i)));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL tw2_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL tw2_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_upd();
        int k = 0;
        logic hit = 1'b0;
        clear_mon();
        ch_mask = 8'hFF;
        en = 1'b1;
        step();
        en = 1'b0;
        while (!hit && k < 40) begin
            step();
            k++;
            if (word_valid && word_data == 24'h1F0000) begin
                word_ready = 1'b0;
                hit = 1'b1;
            end
        end
        n_checks++; if (hit !== 1'b1) $display("FAIL rupd_seen: got %b want 1", hit); else n_pass++;
        repeat (2) step();
        n_checks++; if (word_valid !== 1'b1) $display("FAIL rupd_hold: got %b want 1", word_valid); else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++; if (word_valid !== 1'b0) $display("FAIL rupd_valid: got %b want 0", word_valid); else n_pass++;
        n_checks++; if (word_data !== 24'h0) $display("FAIL rupd_data: got %h want 000000", word_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rupd_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (scan_done !== 1'b0) $display("FAIL rupd_done: got %b want 0", scan_done); else n_pass++;
        rst_n = 1'b1;
        word_ready = 1'b1;
        clear_mon();
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done(1, 60);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr_word(i, 16'h0000));
        exp_q.push_back(24'h1F0000);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rupd_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            n_checks++; if (a !== exp_q[i]) $display("FAIL rupd_word%0d: got %h want %h", i, a, exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ch_mask = 8'h00;
        tbl_we = 1'b0; tbl_addr = 3'd0; tbl_data = 16'h0; word_ready = 1'b1;
        test_reset();
        test_full_scan();
        test_sparse();
        test_backpressure();
        test_en_drop();
        test_table_write();
        test_reset_mid_upd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_scan_sequencer.md
Name: dac_scan_sequencer

Overview:
- Upstream feeder for the serial DAC frame writer in the multipath scan design.
- Holds a per-channel 16-bit code table and walks the enabled channels in ascending order.
- For each enabled channel it issues one 24-bit command word over a valid/ready handshake.
- Each scan ends with an update-all word, followed by a programmable idle gap, and repeats while enabled.

Parameters:
- NUM_CH, 8, number of DAC channels (max 16).
- CH_W, 3, channel index width (clog2 NUM_CH).
- DATA_W, 16, DAC code width.
- CMD_WRITE, 4'h0, command nibble for a channel write.
- CMD_UPDATE, 4'h1, command nibble for update-all.
- GAP_CYCLES, 13, idle clk cycles between end of one scan and start of the next (0 allowed).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  scan enable (level).
- ch_mask  in  NUM_CH  channel enable mask; bit i enables channel i.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  CH_W  table write address.
- tbl_data  in  DATA_W  table write data.
- word_valid  out  1  command word valid.
- word_ready  in  1  serializer ready to accept.
- word_data  out  24  {cmd[3:0], addr[3:0], data[15:0]}.
- busy  out  1  high in any state other than IDLE.
- scan_done  out  1  one-cycle pulse after the update word is accepted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - word_valid=0, word_data=0, busy=0, scan_done=0.
  - state=IDLE, ch_idx=0, gap counter=0.
  - All table entries=0.
  - Reset takes priority over every other event, including mid-handshake; word_valid is low the cycle after.
- Table write: tbl_we at an edge writes tbl_data to entry tbl_addr in any state. A same-cycle read of that entry returns the old value (read-before-write).
- State machine:
  - IDLE: when en=1 and ch_mask!=0, latch ch_mask into mask_l, set ch_idx=0, go SCAN. en=1 with ch_mask=0 stays IDLE.
  - SCAN, one channel per cycle:
    - If mask_l[ch_idx]=1: load word_data={CMD_WRITE, ch_idx, table[ch_idx]}, set word_valid=1, go ISSUE.
    - Else, if ch_idx=NUM_CH-1: go UPD_LOAD; otherwise ch_idx+1.
  - ISSUE: hold word_valid and word_data stable until word_valid&&word_ready at an edge. Then word_valid=0; if ch_idx=NUM_CH-1 go UPD_LOAD, else ch_idx+1 and go SCAN.
  - UPD_LOAD: word_data={CMD_UPDATE, 4'hF, 16'h0000}, word_valid=1, go UPD.
  - UPD: hold until handshake. Then word_valid=0 and scan_done=1 for exactly the next cycle.
    - If en=1: gap counter=GAP_CYCLES, go GAP.
    - If en=0: go IDLE.
  - GAP: decrement each cycle. At 0:
    - If en=1 and ch_mask!=0: re-latch mask_l, ch_idx=0, go SCAN.
    - Else go IDLE.
    - GAP_CYCLES=0 leaves GAP the first cycle after entry.
- Handshake rules:
  - word_valid never deasserts without acceptance.
  - word_data never changes while word_valid=1.
  - word_valid does not depend combinationally on word_ready.
- Latency, word_ready held high: IDLE with en sampled → first word_valid 2 edges later. Back-to-back enabled channels produce one word every 2 cycles (ISSUE, SCAN). Each masked channel adds 1 cycle.
- en deassert mid-scan: current scan completes including the update word, then IDLE with no gap.
- ch_mask changes mid-scan have no effect until the next latch.
- busy=1 in SCAN, ISSUE, UPD_LOAD, UPD and GAP.

Test Plan:
- Reset values: hold rst_n=0 with en=1, word_ready=1 → word_valid=0, word_data=0, busy=0, scan_done=0. After release, with table all 0 and ch_mask=8'hFF: words 000000 through 070000, then 1F0000.
- Full scan, mask 8'hFF, table[i]=16'h1000*i+16'h00AB, ready=1:
  - Words 0000AB, 0110AB, …, 0770AB, then 1F0000 in order.
  - scan_done pulses once.
  - Next scan's first word_valid arrives GAP_CYCLES+2 cycles after scan_done.
- Sparse mask 8'h05, ready=1 → only 0000AB, 0220AB, 1F0000. Timing per latency rules, including skip cycles for channels 1 and 3–7.
- Backpressure: ready driven by a pseudo-random pattern at 50% → word_data stable and word_valid held on every stalled cycle. Full 9-word sequence intact with no duplicates.
- en dropped during channel 3 issue → channels 4–7 and 1F0000 still issued, scan_done pulses, then IDLE with busy=0 and no gap.
- Table write of 16'hBEEF to ch 5 during ISSUE of ch 2 → ch 5 word is 05BEEF. Write in the same cycle SCAN loads ch 5 → old value issued; new value appears next scan. rst_n low during UPD stall → word_valid=0 next cycle, table cleared.
